// File: rtl/memprog_arbiter.sv
// rtl/memprog_arbiter.sv - two-port read arbiter in front of an asynchronous-read program memory
//
// Purpose:
//   Shares one asynchronous-read program memory between a CPU fetch port and
//   a debug/dump reader port. A request is granted combinationally in the
//   cycle it is presented. The memory word is captured into the winner's
//   data register at the next rising edge. The matching valid strobe is high
//   for exactly the following cycle.
//
// Configuration macro:
//   MEMPROG_ARBITER_RR_EN
//     defined   : round-robin arbitration with a 1-bit last-grant pointer.
//     undefined : fixed CPU priority, with a 4-bit starvation counter that
//                 lets debug win once it has been denied MAX_WAIT cycles.
//
// Parameters:
//   AW        program-memory word-address width
//   DW        program-memory data width
//   MAX_WAIT  starvation limit for fixed-priority mode (1..15)
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   cpu_req    CPU fetch request (held with cpu_addr until cpu_gnt)
//   cpu_addr   CPU fetch word address
//   cpu_gnt    CPU request accepted this cycle
//   cpu_valid  cpu_data holds the word for the previous CPU grant
//   cpu_data   registered CPU read data
//   dbg_req    debug request (held with dbg_addr until dbg_gnt)
//   dbg_addr   debug word address
//   dbg_gnt    debug request accepted this cycle
//   dbg_valid  dbg_data holds the word for the previous debug grant
//   dbg_data   registered debug read data
//   mem_a      address to program memory (0 when nothing is granted)
//   mem_rd     program-memory read data, combinational from mem_a

module memprog_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset_n,

  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_gnt,
  output logic          cpu_valid,
  output logic [DW-1:0] cpu_data,

  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_valid,
  output logic [DW-1:0] dbg_data,

  output logic [AW-1:0] mem_a,
  input  logic [DW-1:0] mem_rd
);

  // Set when debug should win a cycle in which both ports request.
  logic dbg_wins;

`ifdef MEMPROG_ARBITER_RR_EN

  // Last-grant pointer: 1 = debug was granted last. It resets to debug, so
  // the CPU wins the first conflict after reset.
  logic last_dbg;

  assign dbg_wins = ~last_dbg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_dbg <= 1'b1;
    end else if (cpu_gnt) begin
      last_dbg <= 1'b0;
    end else if (dbg_gnt) begin
      last_dbg <= 1'b1;
    end
  end

`else

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  // Counts consecutive cycles in which debug asked and lost. It cannot climb
  // past WAIT_LIMIT while debug keeps requesting, because reaching the limit
  // hands debug the next grant. The saturation guard only covers an
  // out-of-range MAX_WAIT.
  logic [3:0] wait_cnt;

  assign dbg_wins = (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 4'd0;
    end else if (!dbg_req || dbg_gnt) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

`endif

  // Grants are gated by reset_n directly, so they drop the moment reset is
  // asserted instead of waiting for a clock edge.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset_n) begin
      if (cpu_req && dbg_req) begin
        cpu_gnt = ~dbg_wins;
        dbg_gnt = dbg_wins;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  always_comb begin
    mem_a = '0;
    if (cpu_gnt) begin
      mem_a = cpu_addr;
    end else if (dbg_gnt) begin
      mem_a = dbg_addr;
    end
  end

  // Read return path: capture on the grant edge, then pulse valid for one
  // cycle. Reset clears valid, which discards any read still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_valid <= 1'b0;
      cpu_data  <= '0;
    end else begin
      cpu_valid <= cpu_gnt;
      if (cpu_gnt) begin
        cpu_data <= mem_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbg_valid <= 1'b0;
      dbg_data  <= '0;
    end else begin
      dbg_valid <= dbg_gnt;
      if (dbg_gnt) begin
        dbg_data <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_memprog_arbiter.sv
// tb/tb_memprog_arbiter.sv - self-checking bench for memprog_arbiter

module tb_memprog_arbiter;

  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 8;

  logic          clk;
  logic          reset_n;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_gnt;
  logic          cpu_valid;
  logic [DW-1:0] cpu_data;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_gnt;
  logic          dbg_valid;
  logic [DW-1:0] dbg_data;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_rd;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  assign mem_rd = mem[mem_a];

  memprog_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_gnt   (cpu_gnt),
    .cpu_valid (cpu_valid),
    .cpu_data  (cpu_data),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_gnt   (dbg_gnt),
    .dbg_valid (dbg_valid),
    .dbg_data  (dbg_data),
    .mem_a     (mem_a),
    .mem_rd    (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, kept in terms of the arbitration rules.
  int            dbg_waited;   // consecutive cycles debug asked and lost
  int            last_winner;  // 0 = cpu, 1 = dbg
  logic          m_cv, m_dv;
  logic [DW-1:0] m_cd, m_dd;

  typedef struct {
    logic          c_req;
    logic [AW-1:0] c_addr;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          e_cg;
    logic          e_dg;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    dbg_waited  = 0;
    last_winner = 1;
    m_cv = 1'b0;
    m_dv = 1'b0;
    m_cd = '0;
    m_dd = '0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic c, input logic [AW-1:0] ca, input logic d,
                      input logic [AW-1:0] da, input logic use_tbl,
                      input logic t_cg, input logic t_dg, input string nm);
    logic          m_cg, m_dg, e_cg, e_dg;
    logic [AW-1:0] e_ma;
    cpu_req  = c;
    cpu_addr = ca;
    dbg_req  = d;
    dbg_addr = da;
    m_cg = c;
    m_dg = d;
    if (c && d) begin
`ifdef MEMPROG_ARBITER_RR_EN
      m_dg = (last_winner == 0);
`else
      m_dg = (dbg_waited == MAX_WAIT);
`endif
      m_cg = !m_dg;
    end
    e_cg = use_tbl ? t_cg : m_cg;
    e_dg = use_tbl ? t_dg : m_dg;
    e_ma = e_cg ? ca : (e_dg ? da : '0);
    @(negedge clk);
    chk({nm, " cpu_gnt"},   DW'(cpu_gnt),   DW'(e_cg));
    chk({nm, " dbg_gnt"},   DW'(dbg_gnt),   DW'(e_dg));
    chk({nm, " mem_a"},     DW'(mem_a),     DW'(e_ma));
    chk({nm, " excl"},      DW'(cpu_gnt & dbg_gnt), '0);
    chk({nm, " cpu_valid"}, DW'(cpu_valid), DW'(m_cv));
    chk({nm, " cpu_data"},  cpu_data,       m_cd);
    chk({nm, " dbg_valid"}, DW'(dbg_valid), DW'(m_dv));
    chk({nm, " dbg_data"},  dbg_data,       m_dd);
    m_cv = m_cg;
    m_dv = m_dg;
    if (m_cg) m_cd = mem[ca];
    if (m_dg) m_dd = mem[da];
    if (m_cg) last_winner = 0;
    else if (m_dg) last_winner = 1;
    dbg_waited = (d && !m_dg) ? dbg_waited + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset with requests active, checks the outputs forced low,
  // then releases reset mid-cycle and returns at posedge+1.
  task automatic do_reset(input string nm);
    reset_n  = 1'b0;
    cpu_req  = 1'b1;
    dbg_req  = 1'b1;
    cpu_addr = 10'h155;
    dbg_addr = 10'h2AA;
    #1;
    chk({nm, " rst cpu_gnt"},   DW'(cpu_gnt),   '0);
    chk({nm, " rst dbg_gnt"},   DW'(dbg_gnt),   '0);
    chk({nm, " rst mem_a"},     DW'(mem_a),     '0);
    chk({nm, " rst cpu_valid"}, DW'(cpu_valid), '0);
    chk({nm, " rst dbg_valid"}, DW'(dbg_valid), '0);
    chk({nm, " rst cpu_data"},  cpu_data,       '0);
    chk({nm, " rst dbg_data"},  dbg_data,       '0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[5]    = 32'hDEADBEEF;
    mem[1023] = 32'hC0FFEE11;

    reset_n  = 1'b1;
    cpu_req  = 1'b0;
    dbg_req  = 1'b0;
    cpu_addr = '0;
    dbg_addr = '0;
    model_reset();
    #3;

    // Directed table, applied from reset.
`ifdef MEMPROG_ARBITER_RR_EN
    tbl.push_back('{1'b1, 10'h010, 1'b1, 10'h020, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 10'h011, 1'b1, 10'h021, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 10'h012, 1'b1, 10'h022, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 10'h013, 1'b1, 10'h023, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0});
`else
    for (int i = 1; i <= 12; i++)
      tbl.push_back('{1'b1, 10'(16 + i), 1'b1, 10'h020, (i != 9), (i == 9)});
    tbl.push_back('{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0});
`endif
    tbl.push_back('{1'b1, 10'h005, 1'b0, 10'h000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 10'h000, 1'b1, 10'h3FF, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0});

    do_reset("init");
    foreach (tbl[i])
      step(tbl[i].c_req, tbl[i].c_addr, tbl[i].d_req, tbl[i].d_addr,
           1'b1, tbl[i].e_cg, tbl[i].e_dg, $sformatf("tbl%0d", i));

    // Spot values of the known memory words.
    chk("deadbeef cpu_data", cpu_data, 32'hDEADBEEF);
    chk("top-word dbg_data", dbg_data, 32'hC0FFEE11);

    // Reset in the cycle after a CPU grant discards the read.
    step(1'b1, 10'h005, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, "pre-rst grant");
    do_reset("midop");
    step(1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, "post-rst idle");

    // Debug asks, gets dropped before a grant, then the counter restarts.
    for (int i = 0; i < 3; i++)
      step(1'b1, 10'h040, 1'b1, 10'h050, 1'b0, 1'b0, 1'b0, "drop-both");
    step(1'b1, 10'h041, 1'b0, 10'h050, 1'b1, 1'b1, 1'b0, "drop-gone");
`ifndef MEMPROG_ARBITER_RR_EN
    for (int i = 1; i <= 10; i++)
      step(1'b1, 10'h042, 1'b1, 10'h051, 1'b1, (i != 9), (i == 9),
           $sformatf("restart%0d", i));
`endif
    step(1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, "drop-idle");

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      logic          c, d;
      logic [AW-1:0] ca, da;
      c  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 3) != 0);
      ca = ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom);
      da = ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom);
      if (i == 200) do_reset("rand");
      step(c, ca, d, da, 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
